// File: rtl/sr_bank.sv
// sr_bank: WIDTH independent, clocked set/reset flags with active-low request
// inputs, per-input glitch filtering, a selectable conflict policy, a
// synchronous global clear and registered change/conflict event pulses.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   n_set     [WIDTH] per-channel set request, active-low, level-sensitive
//   n_reset   [WIDTH] per-channel reset request, active-low, level-sensitive
//   clr       synchronous global clear, active-high, highest priority
//   q         [WIDTH] registered flag state
//   nq        [WIDTH] ~q, derived combinationally
//   changed   [WIDTH] one-cycle pulse per bit whose q changed at the last edge
//   conflict  [WIDTH] one-cycle pulse per bit where set and reset were both
//                     effective at the last edge

// ---------------------------------------------------------------------------
// sr_filt: one glitch filter. The raw input only becomes effective once it has
// been seen low on FILTER earlier consecutive edges, so a request must be held
// for FILTER+1 edges before it acts. Any high sample, or a clear, restarts it.
//   raw_n  active-low raw request
//   eff    request is effective at the coming edge
// ---------------------------------------------------------------------------
module sr_filt #(
  parameter int FILTER = 2,
  parameter int CW     = (FILTER < 1) ? 1 : $clog2(FILTER + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic raw_n,
  output logic eff
);

  localparam logic [CW-1:0] FMAX = CW'(FILTER);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (!clr && !raw_n) begin
      // saturate at FILTER so a long-held request stays effective
      cnt_d = (cnt_q == FMAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign eff = !raw_n && (cnt_q == FMAX);

endmodule

// ---------------------------------------------------------------------------
// sr_lane: one channel. Two filters feed the set/reset update rule; clr wins
// over everything and also drops that edge's conflict indication.
//   n_set/n_reset  raw active-low requests for this channel
//   q/nq           flag and its complement
//   changed        q moved at the last edge
//   conflict       both requests effective at the last edge
// ---------------------------------------------------------------------------
module sr_lane #(
  parameter int   FILTER  = 2,
  parameter int   MODE    = 0,
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic n_set,
  input  logic n_reset,
  output logic q,
  output logic nq,
  output logic changed,
  output logic conflict
);

  logic s_eff, r_eff;
  logic q_q, q_d;
  logic changed_q, changed_d;
  logic conflict_q, conflict_d;

  sr_filt #(.FILTER(FILTER)) u_filt_s (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .raw_n (n_set),
    .eff   (s_eff)
  );

  sr_filt #(.FILTER(FILTER)) u_filt_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .raw_n (n_reset),
    .eff   (r_eff)
  );

  always_comb begin
    q_d        = q_q;
    conflict_d = 1'b0;
    if (clr) begin
      q_d = RESET_Q;
    end else begin
      case ({s_eff, r_eff})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          conflict_d = 1'b1;
          case (MODE)
            0:       q_d = 1'b0;   // reset-dominant
            1:       q_d = 1'b1;   // set-dominant
            2:       q_d = q_q;    // hold
            default: q_d = ~q_q;   // toggle
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    changed_d = q_d ^ q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= RESET_Q;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign nq       = ~q_q;
  assign changed  = changed_q;
  assign conflict = conflict_q;

endmodule

// ---------------------------------------------------------------------------
// sr_bank: array of independent lanes sharing clock, reset and clear.
// ---------------------------------------------------------------------------
module sr_bank #(
  parameter int               WIDTH   = 8,
  parameter int               FILTER  = 2,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] RESET_Q = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] n_set,
  input  logic [WIDTH-1:0] n_reset,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_lane #(
      .FILTER  (FILTER),
      .MODE    (MODE),
      .RESET_Q (RESET_Q[i])
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .n_set    (n_set[i]),
      .n_reset  (n_reset[i]),
      .q        (q[i]),
      .nq       (nq[i]),
      .changed  (changed[i]),
      .conflict (conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_bank.sv
// Bench for sr_bank. Instances 0..3 are FILTER=2 with MODE 0..3 sharing one
// stimulus set; instance 4 is FILTER=0, MODE=0, RESET_Q=8'hA5 with its own.
// A flag-level model tracks every instance and is compared each negedge;
// directed steps add hand-computed literal expectations.
module tb_sr_bank;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] n_set_a = 8'hFF, n_reset_a = 8'hFF;
  logic [7:0] n_set_b = 8'hFF, n_reset_b = 8'hFF;
  logic clr_a = 1'b0, clr_b = 1'b0;

  logic [7:0] q_o [NI];
  logic [7:0] nq_o[NI];
  logic [7:0] ch_o[NI];
  logic [7:0] cf_o[NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_bank #(.WIDTH(8), .FILTER(2), .MODE(g), .RESET_Q(8'h00)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .n_set    (n_set_a),
      .n_reset  (n_reset_a),
      .clr      (clr_a),
      .q        (q_o[g]),
      .nq       (nq_o[g]),
      .changed  (ch_o[g]),
      .conflict (cf_o[g])
    );
  end

  sr_bank #(.WIDTH(8), .FILTER(0), .MODE(0), .RESET_Q(8'hA5)) u_dut_f0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .n_set    (n_set_b),
    .n_reset  (n_reset_b),
    .clr      (clr_b),
    .q        (q_o[4]),
    .nq       (nq_o[4]),
    .changed  (ch_o[4]),
    .conflict (cf_o[4])
  );

  // ---------------- model ----------------
  int         m_filt[NI] = '{2, 2, 2, 2, 0};
  int         m_mode[NI] = '{0, 1, 2, 3, 0};
  logic [7:0] m_rq  [NI] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
  logic [7:0] m_q [NI];
  logic [7:0] m_ch[NI];
  logic [7:0] m_cf[NI];
  int         m_cs[NI][8];   // consecutive low samples seen on set, capped
  int         m_cr[NI][8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_q[k]  <= m_rq[k];
        m_ch[k] <= 8'h00;
        m_cf[k] <= 8'h00;
        for (int i = 0; i < 8; i++) begin
          m_cs[k][i] <= 0;
          m_cr[k][i] <= 0;
        end
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        automatic logic [7:0] ns = (k < 4) ? n_set_a : n_set_b;
        automatic logic [7:0] nr = (k < 4) ? n_reset_a : n_reset_b;
        automatic logic       c  = (k < 4) ? clr_a : clr_b;
        automatic logic [7:0] qn = m_q[k];
        automatic logic [7:0] cf = 8'h00;
        if (c) begin
          qn = m_rq[k];
          for (int i = 0; i < 8; i++) begin
            m_cs[k][i] <= 0;
            m_cr[k][i] <= 0;
          end
        end else begin
          for (int i = 0; i < 8; i++) begin
            automatic bit s = !ns[i] && (m_cs[k][i] == m_filt[k]);
            automatic bit r = !nr[i] && (m_cr[k][i] == m_filt[k]);
            m_cs[k][i] <= ns[i] ? 0 : ((m_cs[k][i] + 1 > m_filt[k]) ? m_filt[k] : m_cs[k][i] + 1);
            m_cr[k][i] <= nr[i] ? 0 : ((m_cr[k][i] + 1 > m_filt[k]) ? m_filt[k] : m_cr[k][i] + 1);
            if (s && r) begin
              cf[i] = 1'b1;
              if (m_mode[k] == 0)      qn[i] = 1'b0;
              else if (m_mode[k] == 1) qn[i] = 1'b1;
              else if (m_mode[k] == 3) qn[i] = ~m_q[k][i];
            end else if (s) begin
              qn[i] = 1'b1;
            end else if (r) begin
              qn[i] = 1'b0;
            end
          end
        end
        m_ch[k] <= qn ^ m_q[k];
        m_cf[k] <= cf;
        m_q[k]  <= qn;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("q[%0d]", k),        q_o[k],  m_q[k]);
      chk($sformatf("nq[%0d]", k),       nq_o[k], ~m_q[k]);
      chk($sformatf("changed[%0d]", k),  ch_o[k], m_ch[k]);
      chk($sformatf("conflict[%0d]", k), cf_o[k], m_cf[k]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    step(2);
    chk("rst q0", q_o[0], 8'h00);
    chk("rst nq0", nq_o[0], 8'hFF);
    chk("rst q4", q_o[4], 8'hA5);
    chk("rst ch0", ch_o[0], 8'h00);
    rst_n = 1'b1;

    // set bit 3: effective on the 3rd edge
    n_set_a = 8'hF7; step(3);
    chk("set3 q", q_o[0], 8'h08);
    chk("set3 nq", nq_o[0], 8'hF7);
    chk("set3 ch", ch_o[0], 8'h08);
    n_set_a = 8'hFF; step(1);
    chk("set3 ch drop", ch_o[0], 8'h00);
    n_set_a = 8'hF7; step(2);
    n_set_a = 8'hFF; step(1);
    chk("short set q", q_o[0], 8'h08);
    chk("short set ch", ch_o[0], 8'h00);

    // glitch on reset bit 3: low-high-low-low-low
    n_reset_a = 8'hF7; step(1);
    n_reset_a = 8'hFF; step(1);
    n_reset_a = 8'hF7; step(2);
    chk("glitch q e4", q_o[0], 8'h08);
    step(1);
    chk("glitch q e5", q_o[0], 8'h00);
    chk("glitch ch e5", ch_o[0], 8'h08);
    n_reset_a = 8'hFF; step(1);

    // conflict on bit 0, starting from q[0]=1 in all modes
    n_set_a = 8'hFE; step(3);
    n_set_a = 8'hFF; step(1);
    n_set_a = 8'hFE; n_reset_a = 8'hFE; step(2);
    chk("cf pre cf0", cf_o[0], 8'h00);
    step(1);
    chk("cf m0 q", q_o[0], 8'h00);
    chk("cf m1 q", q_o[1], 8'h01);
    chk("cf m2 q", q_o[2], 8'h01);
    chk("cf m3 q", q_o[3], 8'h00);
    chk("cf m0 cf", cf_o[0], 8'h01);
    chk("cf m2 cf", cf_o[2], 8'h01);
    step(1);
    chk("cf m3 toggle", q_o[3], 8'h01);
    chk("cf m3 cf again", cf_o[3], 8'h01);
    chk("cf m1 cf again", cf_o[1], 8'h01);
    n_set_a = 8'hFF; n_reset_a = 8'hFF; step(1);
    chk("cf released", cf_o[0], 8'h00);

    // clr in the middle of a filter count restarts it
    n_set_a = 8'hFD; step(2);
    clr_a = 1'b1; step(1);
    chk("clr q0", q_o[0], 8'h00);
    chk("clr ch1", ch_o[1], 8'h01);
    clr_a = 1'b0; step(2);
    chk("clr restart q0", q_o[0], 8'h00);
    step(1);
    chk("clr restart set", q_o[0], 8'h02);
    n_set_a = 8'hFF;

    // FILTER=0 instance
    n_reset_b = 8'h00; step(1);
    chk("f0 rst all", q_o[4], 8'h00);
    chk("f0 rst ch", ch_o[4], 8'hA5);
    n_reset_b = 8'hFF; n_set_b = 8'hF0; step(1);
    chk("f0 set q", q_o[4], 8'h0F);
    chk("f0 set ch", ch_o[4], 8'h0F);
    n_set_b = 8'h00; n_reset_b = 8'h00; clr_b = 1'b1; step(1);
    chk("f0 clr q", q_o[4], 8'hA5);
    chk("f0 clr ch", ch_o[4], 8'hAA);
    chk("f0 clr cf", cf_o[4], 8'h00);
    clr_b = 1'b0; n_set_b = 8'hFE; n_reset_b = 8'hFE; step(1);
    chk("f0 cf q", q_o[4], 8'hA4);
    chk("f0 cf", cf_o[4], 8'h01);
    n_set_b = 8'hFF; n_reset_b = 8'hFF;

    // async reset while q=FF, set held through release
    n_set_a = 8'h00; step(3);
    chk("all set", q_o[0], 8'hFF);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async q0", q_o[0], 8'h00);
    chk("async nq0", nq_o[0], 8'hFF);
    chk("async ch0", ch_o[0], 8'h00);
    chk("async q4", q_o[4], 8'hA5);
    step(2);
    rst_n = 1'b1; step(2);
    chk("post rst e2", q_o[0], 8'h00);
    step(1);
    chk("post rst e3", q_o[0], 8'hFF);
    chk("post rst ch", ch_o[0], 8'hFF);
    n_set_a = 8'hFF; step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_bank.md
Name: sr_bank

Overview:
- Clocked, parametrised successor to the single active-low SR latch: WIDTH independent set/reset channels with complementary q/nq outputs.
- Adds per-channel input glitch filtering, a selectable set/reset conflict policy, a synchronous global clear, and change/conflict event pulses.
- Sits between raw active-low control/status strobes and downstream logic that needs clean, sticky, clock-domain-aligned flags.

Parameters:
- WIDTH, 8, number of independent channels.
- FILTER, 2, consecutive rising edges an input must already have been seen asserted before it takes effect; 0 disables filtering.
- MODE, 0, conflict policy when set and reset are both effective: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
- RESET_Q, {WIDTH{1'b0}}, per-bit value of q after reset or clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- n_set  in  WIDTH  per-channel set request, active-low.
- n_reset  in  WIDTH  per-channel reset request, active-low.
- clr  in  1  synchronous global clear, active-high.
- q  out  WIDTH  registered state.
- nq  out  WIDTH  always ~q.
- changed  out  WIDTH  one-cycle pulse per bit whose q changed at the last edge.
- conflict  out  WIDTH  one-cycle pulse per bit where set and reset were both effective at the last edge.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). While rst_n=0: q=RESET_Q, nq=~RESET_Q, changed=0, conflict=0, all filter counters=0. Deassertion takes effect at the next rising edge.
- Filter, per channel and per input: counter cnt, width clog2(FILTER+1), minimum 1.
  - Each edge, if raw input is low: cnt<=min(cnt+1,FILTER); otherwise cnt<=0.
  - The input is effective at an edge iff raw is low and cnt==FILTER at that edge.
  - So q responds at the (FILTER+1)th consecutive edge with the input low. FILTER=0 means the first such edge.
  - Any high sample restarts the count.
- Update rule at each edge, per bit, with s=effective set and r=effective reset:
  - s only: q<=1.
  - r only: q<=0.
  - Neither: hold.
  - Both: MODE 0 gives q<=0, MODE 1 gives q<=1, MODE 2 holds, MODE 3 gives q<=~q, and conflict<=1.
- Requests are level-sensitive. A held request keeps re-asserting its value. A held double request in MODE 3 toggles q every edge.
- changed[i]<=(new q[i] != old q[i]). It is registered and high for exactly the cycle after the edge that changed q.
- conflict[i] is high for one cycle after each edge with both requests effective. It is re-asserted every edge while the condition persists.
- clr=1 at an edge has highest priority:
  - q<=RESET_Q and all counters<=0.
  - conflict<=0.
  - changed flags bits where q differed from RESET_Q.
  - Inputs sampled on that edge are discarded, so the filter restarts counting on the next edge.
- Channels are fully independent. No cross-channel interaction other than clr.
- nq is derived combinationally from q and must never equal q, including during reset.
- Asserting rst_n mid-filter-count or mid-toggle discards all progress immediately.

Test Plan:
- WIDTH=8, FILTER=2, MODE=0: n_set[3] low for 3 edges -> q=8'h08, nq=8'hF7 after the 3rd edge, changed=8'h08 for one cycle. Low for only 2 edges, then high -> q unchanged, changed=0.
- Glitch: n_reset[3] low-high-low-low-low from q=8'h08 -> q still 8'h08 after the 4th edge, q=8'h00 after the 5th. Requires the count restart on the high sample.
- Conflict, both inputs of bit 0 held low ≥3 edges: MODE 0 -> q[0]=0; MODE 1 -> q[0]=1; MODE 2 -> q[0] unchanged; MODE 3 -> q[0] toggles every edge after the 3rd. conflict[0] pulses each qualifying edge in all modes.
- FILTER=0: n_set=8'hF0 for one edge -> q=8'h0F immediately, changed=8'h0F. Then clr=1 with RESET_Q=8'hA5 -> q=8'hA5, changed=8'hAA, conflict=0.
- Async reset: drop rst_n between clock edges while q=8'hFF -> q=RESET_Q and changed=0 without waiting for an edge. With n_set held low through reset release, q sets after FILTER+1 edges.
- Every cycle of every test: nq == ~q. changed is never high for two consecutive cycles without a q change at each edge.
